// File: rtl/regfile_mp.sv
// Multi-port register file: two registered write-first read ports, one write port,
// and a DEPTH-cycle clear sweep started by reset or clr_req.
module regfile_mp #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    input  logic [ADDR_W-1:0] Rw,
    input  logic              WrEn,
    input  logic [WIDTH-1:0]  busW,
    input  logic              clr_req,
    output logic [WIDTH-1:0]  busA,
    output logic [WIDTH-1:0]  busB,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  busA_q, busA_d;
    logic [WIDTH-1:0]  busB_q, busB_d;
    logic              busy_q, busy_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busA_d    = busA_q;
        busB_d    = busB_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = Rw;
        mem_wdata = busW;
        case (state_q)
            IDLE: begin
                // Zero register wins over the bypass; bypass wins over storage.
                if (ZERO_REG && Ra == '0)      busA_d = '0;
                else if (WrEn && Rw == Ra)     busA_d = busW;
                else                           busA_d = mem_q[Ra];
                if (ZERO_REG && Rb == '0)      busB_d = '0;
                else if (WrEn && Rw == Rb)     busB_d = busW;
                else                           busB_d = mem_q[Rb];
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end else if (WrEn && !(ZERO_REG && Rw == '0)) begin
                    mem_we = 1'b1;
                end
            end
            CLEAR: begin
                busA_d    = '0;
                busB_d    = '0;
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busA_q  <= '0;
            busB_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busA_q  <= busA_d;
            busB_q  <= busB_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; the sweep is the only clearing path.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign busA = busA_q;
    assign busB = busB_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (ZERO_REG=1 and ZERO_REG=0) against a
// behavioural model, a directed vector table and multi-cycle corner sequences.
module tb_regfile_mp;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ra = '0, rb = '0, rw = '0;
    logic        we = 1'b0, clr = 1'b0;
    logic [15:0] wd = '0;
    logic [15:0] busA1, busB1, busA0, busB0;
    logic        busy1, busy0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(16), .ADDR_W(5), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .Ra(ra), .Rb(rb), .Rw(rw), .WrEn(we), .busW(wd),
        .clr_req(clr), .busA(busA1), .busB(busB1), .busy(busy1));
    regfile_mp #(.WIDTH(16), .ADDR_W(5), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .Ra(ra), .Rb(rb), .Rw(rw), .WrEn(we), .busW(wd),
        .clr_req(clr), .busA(busA0), .busB(busB0), .busy(busy0));

    // Model: index 1 = ZERO_REG=1 instance, index 0 = ZERO_REG=0 instance.
    logic [15:0] mm [2][DEPTH];
    int          sweep_left [2];
    logic [15:0] ea [2];
    logic [15:0] eb [2];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            sweep_left[m] = DEPTH;
            ea[m] = '0;
            eb[m] = '0;
        end
    endtask

    task automatic model_step(input int m, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] w, input logic we_i,
                              input logic [15:0] wd_i, input logic clr_i);
        bit zr;
        zr = (m == 1);
        if (sweep_left[m] > 0) begin
            mm[m][DEPTH - sweep_left[m]] = '0;
            sweep_left[m]--;
            ea[m] = '0;
            eb[m] = '0;
        end else begin
            ea[m] = (zr && a == 0) ? 16'h0 : (we_i && w == a) ? wd_i : mm[m][a];
            eb[m] = (zr && b == 0) ? 16'h0 : (we_i && w == b) ? wd_i : mm[m][b];
            if (clr_i) sweep_left[m] = DEPTH;
            else if (we_i && !(zr && w == 0)) mm[m][w] = wd_i;
        end
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                         input logic we_i, input logic [15:0] wd_i, input logic clr_i);
        ra = a; rb = b; rw = w; we = we_i; wd = wd_i; clr = clr_i;
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m, a, b, w, we_i, wd_i, clr_i);
        #1;
        check("busA_zr1", busA1, ea[1]);
        check("busB_zr1", busB1, eb[1]);
        check("busy_zr1", {15'd0, busy1}, {15'd0, sweep_left[1] > 0});
        check("busA_zr0", busA0, ea[0]);
        check("busB_zr0", busB0, eb[0]);
        check("busy_zr0", {15'd0, busy0}, {15'd0, sweep_left[0] > 0});
        we = 1'b0; clr = 1'b0;
    endtask

    // Counts edges until busy drops; noisy=1 adds WrEn/clr_req traffic during the sweep.
    task automatic run_sweep(input string name, input bit noisy);
        int cnt;
        cnt = 0;
        do begin
            if (noisy)
                drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                      16'($urandom), ($urandom_range(0, 3) == 0));
            else
                drive(5'd0, 5'd0, 5'd0, 1'b0, 16'h0, 1'b0);
            cnt++;
        end while (busy1 && cnt < 100);
        check(name, 16'(cnt), 16'd32);
    endtask

    typedef struct {
        logic [4:0]  ra, rb, rw;
        logic        we;
        logic [15:0] wd;
        logic [15:0] a1, b1, a0, b0;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 16'hBEEF, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};
        tbl[1] = '{5'd5,  5'd5,  5'd0,  1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        tbl[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
        tbl[3] = '{5'd0,  5'd5,  5'd7,  1'b0, 16'h5555, 16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF};
        tbl[4] = '{5'd31, 5'd30, 5'd31, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        tbl[5] = '{5'd31, 5'd0,  5'd1,  1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h1234};
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < DEPTH; i++) mm[m][i] = '0;

        // Reset: asynchronous assertion, held state
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_busA", busA1, 16'h0);
        check("rst_busB", busB1, 16'h0);
        check("rst_busy", {15'd0, busy1}, 16'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_sweep("busy_len_after_reset", 1'b0);
        drive(5'd7, 5'd7, 5'd0, 1'b0, 16'h0, 1'b0);
        check("read7_after_sweep", busA1, 16'h0);

        // Directed table: bypass, zero register, storage reads
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].ra, tbl[i].rb, tbl[i].rw, tbl[i].we, tbl[i].wd, 1'b0);
            check($sformatf("tbl%0d_A_zr1", i), busA1, tbl[i].a1);
            check($sformatf("tbl%0d_B_zr1", i), busB1, tbl[i].b1);
            check($sformatf("tbl%0d_A_zr0", i), busA0, tbl[i].a0);
            check($sformatf("tbl%0d_B_zr0", i), busB0, tbl[i].b0);
        end

        // Reset mid-operation: outputs drop between clock edges
        drive(5'd5, 5'd31, 5'd0, 1'b0, 16'h0, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midop_rst_busA", busA1, 16'h0);
        check("midop_rst_busB", busB1, 16'h0);
        check("midop_rst_busy", {15'd0, busy1}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        run_sweep("busy_len_after_midop_rst", 1'b0);

        // Fill 1..31, clear with noisy traffic, verify all zero
        for (int i = 1; i < DEPTH; i++)
            drive(5'(i), 5'(i - 1), 5'(i), 1'b1, 16'(i), 1'b0);
        drive(5'd9, 5'd17, 5'd0, 1'b0, 16'h0, 1'b0);
        check("fill_A9", busA1, 16'd9);
        check("fill_B17", busB1, 16'd17);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 16'h0, 1'b1);
        run_sweep("busy_len_clr_req", 1'b1);
        for (int i = 0; i < DEPTH; i += 2) begin
            drive(5'(i), 5'(i + 1), 5'd0, 1'b0, 16'h0, 1'b0);
            check("post_clr_A0", busA0, 16'h0);
            check("post_clr_B0", busB0, 16'h0);
        end

        // Reset at sweep edge 10, between edges
        for (int i = 1; i < DEPTH; i++)
            drive(5'd0, 5'd0, 5'(i), 1'b1, 16'(i * 3), 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 10; i++) drive(5'd4, 5'd8, 5'd0, 1'b0, 16'h0, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("sweep_rst_busA", busA1, 16'h0);
        check("sweep_rst_busy", {15'd0, busy1}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        run_sweep("busy_len_after_sweep_rst", 1'b0);

        // Same-edge write and clr_req: write dropped
        drive(5'd3, 5'd3, 5'd3, 1'b1, 16'h00AA, 1'b0);
        drive(5'd1, 5'd2, 5'd3, 1'b1, 16'h00AA, 1'b1);
        run_sweep("busy_len_wr_clr", 1'b0);
        drive(5'd3, 5'd3, 5'd0, 1'b0, 16'h0, 1'b0);
        check("entry3_after_wr_clr", busA1, 16'h0);
        check("entry3_after_wr_clr_zr0", busB0, 16'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++)
            drive(5'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0),
                  16'($urandom), ($urandom_range(0, 59) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
